// File: rtl/sm_gpio_in.sv
// GPIO input conditioning: two-flop synchronizer, per-bit debounce, change strobe.
// Optional sticky rising-edge flags are enabled by defining SM_GPIO_EDGE_EN.
module sm_gpio_in #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpioIn,
    output logic [WIDTH-1:0] exData,
    output logic             exChanged,
    output logic [WIDTH-1:0] riseFlags,
    input  logic [WIDTH-1:0] edgeClr
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic             changed_q, changed_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];

    always_comb begin
        s1_d     = gpioIn;
        s2_d     = s1_q;
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                // Terminal count: accept the new level and restart idle.
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
        changed_d = |(stable_d ^ stable_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign exData    = stable_q;
    assign exChanged = changed_q;

`ifdef SM_GPIO_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;

    // Set is applied after clear so a coincident rise keeps the flag.
    always_comb begin
        rise_d = (rise_q & ~edgeClr) | (stable_d & ~stable_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
        end else begin
            rise_q <= rise_d;
        end
    end

    assign riseFlags = rise_q;
`else
    logic unused_edge_clr;
    assign unused_edge_clr = ^edgeClr;
    assign riseFlags       = '0;
`endif

endmodule

// File: doc/sm_gpio_in.md
# sm_gpio_in

Input conditioning stage for the 8-bit external data bus read by the CPU's external-data instruction. Pins from board switches and buttons pass through a two-flop synchronizer and a per-bit debounce filter. The result is presented as a stable registered `exData` word that the CPU sign-extends and writes to the register file. The block also provides a change-strobe and optional sticky rising-edge flags for future polled-input software.

## Interface
Parameters:
- `WIDTH`, 8, number of GPIO input bits; the CPU consumes 8.
- `DEBOUNCE_CYCLES`, 16, consecutive cycles a synchronized bit must differ from its stable value before the stable value flips. Legal range is 1..65535.

Ports:
- `clk`, in, 1, system clock; all state updates on the rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `gpioIn`, in, WIDTH, raw asynchronous pin levels.
- `exData`, out, WIDTH, debounced stable value; connects to the CPU `exData`.
- `exChanged`, out, 1, one-cycle pulse: at least one `exData` bit changed on the last edge.
- `riseFlags`, out, WIDTH, sticky per-bit debounced 0→1 flags. Valid only with the feature macro defined.
- `edgeClr`, in, WIDTH, per-bit clear for `riseFlags`. Ignored without the feature macro.

## Operation
- Synchronizer, per bit:
  - `s1 <= gpioIn`.
  - `s2 <= s1`.
  - Only `s2` is used downstream.
- Debounce, per bit, with an independent counter `cnt` of width max(1, $clog2(DEBOUNCE_CYCLES)):
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt != DEBOUNCE_CYCLES-1`: `cnt <= cnt + 1`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
- A disagreement shorter than DEBOUNCE_CYCLES consecutive cycles is discarded. Any single agreeing cycle restarts the count from 0.
- `exData = stable`. It is a direct register output with no combinational path from `gpioIn`.
- `exChanged` is registered. It goes high on the same edge at which any `stable` bit flips, and low on the next edge unless another flip occurs then.
- Bits are fully independent. Simultaneous flips on several bits produce one `exChanged` pulse.
- No state machine beyond the per-bit counters; each bit is either idle (cnt = 0) or counting.
- Reset (asynchronous, any time, including mid-count) forces all of the following to 0 immediately:
  - `s1`, `s2`
  - `stable`
  - all `cnt`
  - `exChanged`
  - `riseFlags`
- Reset-release behaviour:
  - Pins held high through reset are treated as a change after release.
  - They appear on `exData` after the normal latency.
  - They do pulse `exChanged`.

## Timing
- Edge 0 is the first rising edge at which `s1` samples a new steady level:
  - `s2` takes the new level at edge 1.
  - `exData` and `exChanged` update at edge DEBOUNCE_CYCLES+1.
  - Example: D=4 gives the update at edge 5; D=1 gives the update at edge 2.
- A pulse on `gpioIn` lasting N cycles (N ≥ 1, clean, synchronous to `clk`):
  - N < DEBOUNCE_CYCLES: the pulse is never visible.
  - N ≥ DEBOUNCE_CYCLES: the pulse is visible.
- Counter wrap is impossible, because the terminal compare resets `cnt` before overflow.
- Reset values of all outputs: `exData` = 0, `exChanged` = 0, `riseFlags` = 0.

## Configuration
- Macro: `SM_GPIO_EDGE_EN`.
- Defined:
  - `riseFlags[i]` is set on the edge where `stable[i]` flips 0→1.
  - `riseFlags[i]` is cleared on any edge with `edgeClr[i]` = 1.
  - Simultaneous set and clear on the same bit: set wins, so the flag stays 1.
  - Flags hold until cleared or reset.
- Undefined:
  - `riseFlags` is tied to 0.
  - `edgeClr` is unused.
  - No flag registers are synthesized.
  - The port list is identical in both builds.

## Test plan
All tests use WIDTH=8 and DEBOUNCE_CYCLES=4.

1. Reset/steady: hold `rst_n`=0 with `gpioIn`=8'hFF, then release.
   - `exData`=0 during reset.
   - `exData`=8'hFF and a single `exChanged` pulse at edge 5 after release.
2. Glitch rejection: from `exData`=0, drive `gpioIn`=8'h01 for 3 cycles, then 0.
   - `exData` stays 8'h00.
   - `exChanged` never asserts.
3. Accept and independent bits: drive 8'h81 steady.
   - `exData`=8'h81 at edge 5 with one pulse.
   - Then drop bit 7 only: `exData`=8'h01 five edges later, bit 0 untouched.
4. Reset mid-count: start 8'h0F, assert `rst_n`=0 after 2 cycles, release with input still 8'h0F.
   - Outputs are 0 immediately on reset.
   - `exData`=8'h0F at edge 5 after release.
5. With `SM_GPIO_EDGE_EN`:
   - 8'h00→8'h04 sets `riseFlags`=8'h04.
   - Falling back to 0 keeps the flag.
   - `edgeClr`=8'h04 for one cycle clears it.
   - A rise coinciding with `edgeClr` leaves the flag at 1.
